jrb_run_ctrl: RTL and testbench



---
 rtl/jrb_pkg.sv | 14 +
 rtl/jrb_step_debounce.sv | 57 +++++
 rtl/jrb_run_ctrl.sv | 173 +++++++++++++++++
 tb/tb_jrb_run_ctrl.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jrb_pkg.sv
// Shared definitions for the jrb8 run controller: FSM state encoding.
package jrb_pkg;

    localparam int STATE_W = 2;

    // Encoding is visible on the state output, so it is fixed explicitly.
    typedef enum logic [STATE_W-1:0] {
        ST_PAUSE = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_HALT  = 2'b11
    } run_state_t;

endpackage

// File: rtl/jrb_step_debounce.sv
// Step-button conditioning: 2-FF synchroniser followed by a symmetric
// debounce. Emits a single-cycle press pulse per accepted button press.
module jrb_step_debounce #(
    parameter int STEP_DB = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic step_in,
    output logic press
);

    localparam int CW = $clog2(STEP_DB);
    // The capture into the synchroniser counts as the first sample.
    localparam logic [CW-1:0] LAST = CW'(STEP_DB - 2);

    logic          sync_a;
    logic          sync_b;
    logic          armed;
    logic [CW-1:0] run_len;

    // Two-stage synchroniser for the asynchronous button.
    // NOTE: every clocked process uses non-blocking assignments so all
    // registers update from pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= step_in;
            sync_b <= sync_a;
        end
    end

    // While armed, wait for a stable high run; once fired, wait for a stable
    // low run before re-arming. The level being sought is simply 'armed'.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed   <= 1'b1;
            run_len <= '0;
            press   <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_b == armed) begin
                if (run_len == LAST) begin
                    run_len <= '0;
                    armed   <= ~armed;
                    press   <= armed;
                end else begin
                    run_len <= run_len + 1'b1;
                end
            end else begin
                run_len <= '0;
            end
        end
    end

endmodule

// File: rtl/jrb_run_ctrl.sv
// CPU clock/run controller for the jrb8 core: power-of-two clock divider
// with memory-busy stretching, run/pause/step/halt FSM, PC breakpoint and a
// saturating CPU cycle counter.
module jrb_run_ctrl
    import jrb_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int PC_W    = 16,
    parameter int CNT_W   = 24,
    parameter int STEP_DB = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SEL_W-1:0]   div_sel,
    input  logic               mem_ready,
    input  logic               run_req,
    input  logic               step_in,
    input  logic               halt_in,
    input  logic               bp_en,
    input  logic [PC_W-1:0]    bp_addr,
    input  logic [PC_W-1:0]    pc,
    input  logic               clr_count,
    output logic               cpu_clk,
    output logic               cpu_tick,
    output logic [STATE_W-1:0] state,
    output logic               bp_hit,
    output logic               halted,
    output logic [CNT_W-1:0]   cycle_count
);

    // Largest divisor is 2^(2^SEL_W), so the phase counter needs 2^SEL_W bits.
    localparam int CTR_W = 2 ** SEL_W;

    // D/2 - 1 for divisor select 'sel'.
    function automatic logic [CTR_W-1:0] half_m1(input logic [SEL_W-1:0] sel);
        logic [CTR_W-1:0] half;
        half = CTR_W'(1) << sel;
        return half - 1'b1;
    endfunction

    // D - 1 for divisor select 'sel' (D/2 - 1 shifted up with a 1 appended).
    function automatic logic [CTR_W-1:0] full_m1(input logic [SEL_W-1:0] sel);
        logic [CTR_W-1:0] h;
        h = half_m1(sel);
        return {h[CTR_W-2:0], 1'b1};
    endfunction

    run_state_t       cur_state;
    run_state_t       next_state;
    logic [SEL_W-1:0] dq;
    logic [CTR_W-1:0] ctr;
    logic             active;
    logic             period_end;
    logic             start_period;
    logic             bp_set;
    logic             bp_clr;
    logic             step_press;

    jrb_step_debounce #(
        .STEP_DB (STEP_DB)
    ) u_step (
        .clk     (clk),
        .rst     (rst),
        .step_in (step_in),
        .press   (step_press)
    );

    // A parked counter sits at D-1, so idle cycles count as period ends too.
    assign period_end = mem_ready && (ctr == full_m1(dq));
    assign state      = cur_state;
    assign halted     = (cur_state == ST_HALT);

    // Next-state and period-start decisions; stops are only taken at period end.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        next_state   = cur_state;
        start_period = 1'b0;
        bp_set       = 1'b0;
        bp_clr       = 1'b0;
        case (cur_state)
            ST_PAUSE: begin
                if (mem_ready) begin
                    if (run_req) begin
                        next_state = ST_RUN;
                        bp_clr     = 1'b1;
                    end else if (step_press) begin
                        next_state = ST_STEP;
                        bp_clr     = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (period_end) begin
                    if (halt_in) begin
                        next_state = ST_HALT;
                    end else if (bp_en && (pc == bp_addr)) begin
                        next_state = ST_PAUSE;
                        bp_set     = 1'b1;
                    end else if (!run_req) begin
                        next_state = ST_PAUSE;
                    end else begin
                        start_period = 1'b1;
                    end
                end
            end
            ST_STEP: begin
                // First period end starts the single period, the second ends it.
                if (period_end) begin
                    if (!active) begin
                        start_period = 1'b1;
                    end else if (halt_in) begin
                        next_state = ST_HALT;
                    end else begin
                        next_state = ST_PAUSE;
                    end
                end
            end
            default: ;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur_state <= ST_PAUSE;
        else     cur_state <= next_state;
    end

    // Divider: phase counter, divisor latch and registered clock/tick outputs.
    // The divisor only changes at a period end, so no shortened phase exists.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq       <= '0;
            ctr      <= full_m1('0);
            active   <= 1'b0;
            cpu_clk  <= 1'b0;
            cpu_tick <= 1'b0;
        end else begin
            cpu_tick <= 1'b0;
            if (period_end) begin
                dq <= div_sel;
                if (start_period) begin
                    ctr      <= '0;
                    active   <= 1'b1;
                    cpu_clk  <= 1'b1;
                    cpu_tick <= 1'b1;
                end else begin
                    ctr     <= full_m1(div_sel);
                    active  <= 1'b0;
                    cpu_clk <= 1'b0;
                end
            end else if (mem_ready && active) begin
                ctr <= ctr + 1'b1;
                if (ctr == half_m1(dq)) cpu_clk <= 1'b0;
            end
        end
    end

    // Sticky breakpoint flag: set on a breakpoint stop, cleared on leaving PAUSE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         bp_hit <= 1'b0;
        else if (bp_set) bp_hit <= 1'b1;
        else if (bp_clr) bp_hit <= 1'b0;
    end

    // Saturating count of cpu_clk rising edges; clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  cycle_count <= '0;
        else if (clr_count)                       cycle_count <= '0;
        else if (cpu_tick && (cycle_count != '1)) cycle_count <= cycle_count + 1'b1;
    end

endmodule

// File: tb/tb_jrb_run_ctrl.sv
// Self-checking bench for jrb_run_ctrl: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_jrb_run_ctrl;

    localparam int SEL_W   = 3;
    localparam int PC_W    = 16;
    localparam int CNT_W   = 8;
    localparam int STEP_DB = 16;

    localparam int S_PAUSE = 0;
    localparam int S_RUN   = 1;
    localparam int S_STEP  = 2;
    localparam int S_HALT  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [SEL_W-1:0] div_sel;
    logic             mem_ready;
    logic             run_req;
    logic             step_in;
    logic             halt_in;
    logic             bp_en;
    logic [PC_W-1:0]  bp_addr;
    logic [PC_W-1:0]  pc;
    logic             clr_count;
    logic             cpu_clk;
    logic             cpu_tick;
    logic [1:0]       state;
    logic             bp_hit;
    logic             halted;
    logic [CNT_W-1:0] cycle_count;

    jrb_run_ctrl #(
        .SEL_W   (SEL_W),
        .PC_W    (PC_W),
        .CNT_W   (CNT_W),
        .STEP_DB (STEP_DB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .div_sel     (div_sel),
        .mem_ready   (mem_ready),
        .run_req     (run_req),
        .step_in     (step_in),
        .halt_in     (halt_in),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .pc          (pc),
        .clr_count   (clr_count),
        .cpu_clk     (cpu_clk),
        .cpu_tick    (cpu_tick),
        .state       (state),
        .bp_hit      (bp_hit),
        .halted      (halted),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_state;
    int m_div;      // current divisor D
    int m_pos;      // advancing cycles since the current period began
    bit m_active;   // a period is in progress
    bit m_clk;
    bit m_tick;
    bit m_bp;
    int m_cnt;
    bit m_press;    // accepted press, visible to the FSM one cycle later
    bit m_s1;
    bit m_s2;
    bit m_armed;
    int m_run;
    bit pc_auto;

    task automatic model_reset();
        m_state = S_PAUSE; m_div = 2; m_pos = 0; m_active = 0;
        m_clk = 0; m_tick = 0; m_bp = 0; m_cnt = 0;
        m_press = 0; m_s1 = 0; m_s2 = 0; m_armed = 1; m_run = 0;
    endtask

    // One clk edge, using the input values present at that edge.
    task automatic model_step();
        bit old_tick;
        bit old_press;
        bit old_s2;
        bit at_end;
        bit start;
        old_tick  = m_tick;
        old_press = m_press;
        old_s2    = m_s2;
        start     = 0;

        if (clr_count) m_cnt = 0;
        else if (old_tick && m_cnt < (2 ** CNT_W) - 1) m_cnt = m_cnt + 1;

        // STEP_DB equal synchronised samples (the capture itself is the
        // first) flip between armed and disarmed; only arming->firing presses.
        m_press = 0;
        if (old_s2 == m_armed) begin
            m_run = m_run + 1;
            if (m_run == STEP_DB - 1) begin
                m_press = m_armed;
                m_armed = !m_armed;
                m_run   = 0;
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = step_in;

        m_tick = 0;
        if (mem_ready) begin
            at_end = !m_active || (m_pos == m_div - 1);
            case (m_state)
                S_PAUSE: begin
                    if (run_req)        begin m_state = S_RUN;  m_bp = 0; end
                    else if (old_press) begin m_state = S_STEP; m_bp = 0; end
                end
                S_RUN: if (at_end) begin
                    if (halt_in)                      m_state = S_HALT;
                    else if (bp_en && pc == bp_addr) begin m_state = S_PAUSE; m_bp = 1; end
                    else if (!run_req)                m_state = S_PAUSE;
                    else                              start = 1;
                end
                S_STEP: if (at_end) begin
                    if (!m_active)    start = 1;
                    else if (halt_in) m_state = S_HALT;
                    else              m_state = S_PAUSE;
                end
                default: ;
            endcase
            if (at_end) begin
                m_div    = 2 << int'(div_sel);
                m_active = start;
                m_pos    = 0;
                m_tick   = start;
            end else begin
                m_pos = m_pos + 1;
            end
        end
        m_clk = m_active && (m_pos < m_div / 2);
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".cpu_clk"},     cpu_clk,     m_clk);
        check({tag, ".cpu_tick"},    cpu_tick,    m_tick);
        check({tag, ".state"},       state,       m_state);
        check({tag, ".bp_hit"},      bp_hit,      m_bp);
        check({tag, ".halted"},      halted,      m_state == S_HALT);
        check({tag, ".cycle_count"}, cycle_count, m_cnt);
    endtask

    // Advance one clk cycle; called and returning just after a falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model("model");
        if (pc_auto && m_tick) pc = pc + 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        compare_model("reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_tick(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (cpu_tick === 1'b1) break;
        end
        check(name, cpu_tick, 1);
    endtask

    task automatic wait_state(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (state === 2'(target)) break;
            cycle();
        end
        check(name, state, target);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       run_req;
        logic       mem_ready;
        logic       clr;
        logic       clk_e;
        logic       tick_e;
        logic [1:0] st_e;
        int         cnt_e;
    } vec_t;

    vec_t vt[13];

    int ticks;
    int step_cycles;
    int first_step;
    int step_hold;
    int halt_age;
    logic [9:0] div_pat;

    initial begin
        rst = 1'b1; div_sel = '0; mem_ready = 1'b1; run_req = 1'b0; step_in = 1'b0;
        halt_in = 1'b0; bp_en = 1'b0; bp_addr = '0; pc = '0; clr_count = 1'b0;
        pc_auto = 0;

        //         run   mem   clr   clk   tick  state cnt   (D=2)
        vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 0};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 0};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 2};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 3};
        vt[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 3};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4};
        vt[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4};
        vt[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4};
        vt[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 0};

        do_reset();
        check("rst_state", state, S_PAUSE);
        check("rst_clk", cpu_clk, 0);

        for (int i = 0; i < 13; i++) begin
            run_req   = vt[i].run_req;
            mem_ready = vt[i].mem_ready;
            clr_count = vt[i].clr;
            cycle();
            check($sformatf("vec%0d.clk", i),   cpu_clk,     vt[i].clk_e);
            check($sformatf("vec%0d.tick", i),  cpu_tick,    vt[i].tick_e);
            check($sformatf("vec%0d.state", i), state,       vt[i].st_e);
            check($sformatf("vec%0d.cnt", i),   cycle_count, vt[i].cnt_e);
        end
        clr_count = 1'b0;
        mem_ready = 1'b1;

        // Counting and saturation at D=2.
        do_reset();
        run_req = 1'b1;
        for (int i = 0; i < 21; i++) cycle();
        check("count_after_20", cycle_count, 10);
        for (int i = 0; i < 600; i++) cycle();
        check("count_saturated", cycle_count, 255);
        clr_count = 1'b1;
        cycle();
        check("count_cleared", cycle_count, 0);
        clr_count = 1'b0;
        run_req = 1'b0;
        wait_state(S_PAUSE, 10, "count_pause");

        // Divisor change in the middle of a D=8 high phase.
        div_sel = 3'd2;
        cycle();
        run_req = 1'b1;
        wait_tick(20, "div_first_tick");
        check("div_hi1", cpu_clk, 1);
        div_sel = 3'd0;
        div_pat = 10'b1110000101;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check($sformatf("div_seq%0d", i), cpu_clk, div_pat[9 - i]);
        end
        run_req = 1'b0;
        wait_state(S_PAUSE, 10, "div_pause");

        // Memory stall during the high phase at D=4.
        div_sel = 3'd1;
        cycle();
        run_req = 1'b1;
        wait_tick(20, "stall_tick");
        begin
            int cnt0;
            cnt0 = m_cnt;
            mem_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
                cycle();
                check($sformatf("stall_clk%0d", i), cpu_clk, 1);
                check($sformatf("stall_cnt%0d", i), cycle_count, cnt0 + 1);
            end
        end
        mem_ready = 1'b1;
        cycle();
        check("stall_post_hi", cpu_clk, 1);
        cycle();
        check("stall_post_lo", cpu_clk, 0);
        run_req = 1'b0;
        wait_state(S_PAUSE, 10, "stall_pause");

        // Breakpoint at PC 0x0010, then a single step.
        do_reset();
        div_sel = 3'd0; bp_en = 1'b1; bp_addr = 16'h0010; pc = '0; pc_auto = 1;
        run_req = 1'b1;
        cycle();
        ticks = 0;
        for (int i = 0; i < 100 && state != 2'(S_PAUSE); i++) begin
            cycle();
            if (cpu_tick) ticks++;
        end
        run_req = 1'b0;
        check("bp_state", state, S_PAUSE);
        check("bp_hit_set", bp_hit, 1);
        check("bp_ticks", ticks, 16);
        ticks = 0;
        step_cycles = 0;
        for (int i = 0; i < 45; i++) begin
            step_in = (i < 20);
            cycle();
            if (cpu_tick) ticks++;
            if (state == 2'(S_STEP)) step_cycles++;
        end
        check("step_ticks", ticks, 1);
        check("step_len", step_cycles, 3);
        check("step_bp_clr", bp_hit, 0);
        check("step_state", state, S_PAUSE);
        pc_auto = 0; bp_en = 1'b0;

        // Bouncy button: three short glitches, then one stable press.
        ticks = 0;
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 6; i++) begin
                step_in = (i < 3);
                cycle();
                if (cpu_tick) ticks++;
            end
        end
        check("bounce_glitch_ticks", ticks, 0);
        first_step = -1;
        for (int i = 1; i <= 45; i++) begin
            step_in = (i <= 20);
            cycle();
            if (cpu_tick) ticks++;
            if (state == 2'(S_STEP) && first_step < 0) first_step = i;
        end
        check("bounce_ticks", ticks, 1);
        check("bounce_step_latency", first_step, STEP_DB + 2);

        // Halt during RUN; run_req and steps are then ignored until reset.
        run_req = 1'b1;
        wait_tick(20, "halt_tick");
        halt_in = 1'b1;
        wait_state(S_HALT, 10, "halt_state");
        check("halted_flag", halted, 1);
        halt_in = 1'b0;
        ticks = 0;
        for (int i = 0; i < 45; i++) begin
            run_req = i[2];
            step_in = (i < 20);
            cycle();
            if (cpu_tick) ticks++;
        end
        check("halt_no_ticks", ticks, 0);
        check("halt_sticky", state, S_HALT);
        run_req = 1'b0;
        do_reset();
        check("halt_rst_state", state, S_PAUSE);
        check("halt_rst_flag", halted, 0);

        // Randomized traffic against the model.
        step_hold = 0;
        halt_age = 0;
        for (int n = 0; n < 4000; n++) begin
            mem_ready = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 39) == 0) run_req = ~run_req;
            if ($urandom_range(0, 59) == 0) div_sel = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) bp_en = ~bp_en;
            if ($urandom_range(0, 49) == 0) bp_addr = 16'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) pc = 16'($urandom_range(0, 15));
            halt_in   = ($urandom_range(0, 399) == 0);
            clr_count = ($urandom_range(0, 49) == 0);
            if (step_hold == 0) begin
                step_in   = ($urandom_range(0, 2) == 0);
                step_hold = $urandom_range(1, 40);
            end else begin
                step_hold--;
            end
            if (m_state == S_HALT) halt_age++;
            if (halt_age > 60 || $urandom_range(0, 1499) == 0) begin
                halt_age = 0;
                do_reset();
            end else begin
                cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
